// File: rtl/cache_arbiter_pkg.sv
// Shared types for the instruction/data cache arbiter.
// Holds the arbiter FSM state encoding and the default cache line width.
package cache_arbiter_pkg;

    localparam int unsigned DEFAULT_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates one physical memory port between an instruction cache and a
// data cache. Data requests normally win; after MAX_D_RUN consecutive data
// grants with an instruction read waiting, the instruction side is served.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_read, i_address             instruction-side line read request
//   i_rdata, i_resp               instruction-side read line / completion pulse
//   d_read, d_write, d_address    data-side request (write wins over read)
//   d_wdata                       data-side write line
//   d_rdata, d_resp               data-side read line / completion pulse
//   pmem_read, pmem_write         memory strobes, held until pmem_resp
//   pmem_address, pmem_wdata      memory address / write line (latched copies)
//   pmem_rdata, pmem_resp         memory read line / completion pulse
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W    = DEFAULT_LINE_W,
    parameter int unsigned MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int unsigned CNT_W = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_D_RUN);

    arb_state_t        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [CNT_W-1:0]  run_q, run_d;

    logic d_pend;
    logic i_starved;

    assign d_pend    = d_read | d_write;
    assign i_starved = i_read && (run_q == RUN_MAX);

    // State and holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            run_q   <= run_d;
        end
    end

    // Next-state, holding-register capture and output decode
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        run_d        = run_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        i_resp       = 1'b0;
        i_rdata      = '0;
        d_resp       = 1'b0;
        d_rdata      = '0;

        case (state_q)
            IDLE: begin
                if (d_pend && !i_starved) begin
                    state_d = SERVE_D;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                    write_d = d_write;
                    // Run length only matters while the instruction side waits
                    if (i_read) begin
                        run_d = (run_q == RUN_MAX) ? run_q : run_q + CNT_W'(1);
                    end else begin
                        run_d = '0;
                    end
                end else if (i_read) begin
                    state_d = SERVE_I;
                    addr_d  = i_address;
                    wdata_d = d_wdata;
                    write_d = 1'b0;
                    run_d   = '0;
                end else begin
                    run_d = '0;
                end
            end

            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = pmem_rdata;
                    state_d = IDLE;
                end
            end

            SERVE_D: begin
                pmem_read  = !write_q;
                pmem_write = write_q;
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = pmem_rdata;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Reset cycle drops any in-flight transaction and quiets every output
        if (rst) begin
            pmem_read    = 1'b0;
            pmem_write   = 1'b0;
            pmem_address = '0;
            pmem_wdata   = '0;
            i_resp       = 1'b0;
            i_rdata      = '0;
            d_resp       = 1'b0;
            d_rdata      = '0;
        end
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, width in bits of one cache line on every data bus.
REQ-002 SHALL have parameter MAX_D_RUN, default 4, maximum consecutive data-side grants while an instruction request waits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_read  input  1  instruction-side line read request.
REQ-006 SHALL have port i_address  input  32  instruction-side line address.
REQ-007 SHALL have port i_rdata  output  LINE_W  instruction-side read line.
REQ-008 SHALL have port i_resp  output  1  instruction-side completion pulse.
REQ-009 SHALL have port d_read  input  1  data-side line read request.
REQ-010 SHALL have port d_write  input  1  data-side line write request.
REQ-011 SHALL have port d_address  input  32  data-side line address.
REQ-012 SHALL have port d_wdata  input  LINE_W  data-side write line.
REQ-013 SHALL have port d_rdata  output  LINE_W  data-side read line.
REQ-014 SHALL have port d_resp  output  1  data-side completion pulse.
REQ-015 SHALL have port pmem_read  output  1  memory read strobe.
REQ-016 SHALL have port pmem_write  output  1  memory write strobe.
REQ-017 SHALL have port pmem_address  output  32  memory line address.
REQ-018 SHALL have port pmem_wdata  output  LINE_W  memory write line.
REQ-019 SHALL have port pmem_rdata  input  LINE_W  memory read line.
REQ-020 SHALL have port pmem_resp  input  1  memory completion pulse.

Function
REQ-021 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-022 IDLE: pending data request -> SERVE_D, else pending i_read -> SERVE_I, except d_run_cnt == MAX_D_RUN with i_read pending -> SERVE_I.
REQ-023 On leaving IDLE, SHALL register requester address, d_wdata and op (read/write) into holding registers; pmem_* driven only from these registers.
REQ-024 pmem_read/pmem_write SHALL assert in the first cycle of SERVE_x and hold until the cycle pmem_resp is sampled high.
REQ-025 d_read and d_write both high: write SHALL win; only pmem_write asserted.
REQ-026 In SERVE_x with pmem_resp high, x_resp SHALL be 1 that same cycle, x_rdata = pmem_rdata combinationally; FSM -> IDLE next edge.
REQ-027 i_resp/d_resp SHALL be 0 in every other cycle; i_rdata/d_rdata SHALL be 0 when the matching resp is 0.
REQ-028 Minimum latency: request in IDLE cycle 0 -> pmem strobe cycle 1 -> resp same cycle as pmem_resp; one IDLE cycle between back-to-back transactions.
REQ-029 Requester deasserting before resp: transaction SHALL complete on memory; resp still pulsed once.
REQ-030 Request changes in SERVE_x SHALL not affect pmem_address/pmem_wdata.
REQ-031 d_run_cnt SHALL increment on each SERVE_D entry while i_read high, saturate at MAX_D_RUN, clear on SERVE_I entry or when i_read is low in IDLE.
REQ-032 pmem_resp outside SERVE_x SHALL be ignored.

Reset
REQ-033 rst high at an edge SHALL force IDLE, d_run_cnt = 0, holding registers = 0, regardless of state.
REQ-034 During/after reset: pmem_read, pmem_write, i_resp, d_resp = 0; pmem_address, pmem_wdata, i_rdata, d_rdata = 0.
REQ-035 Reset mid-transaction SHALL drop the transaction; no resp pulsed for it.

Structure
REQ-036 FSM state enum and default LINE_W SHALL live in the shared types package.
REQ-037 Single module; no sub-modules.

Verification
REQ-038 i_read=1, addr 0x0000_1000, pmem_resp after 3 cycles with 0xAA..AA -> pmem_read cycles 1-4, pmem_address 0x1000, i_resp one cycle, i_rdata 0xAA..AA.
REQ-039 i_read and d_read same cycle, addrs 0x100/0x200 -> data served first (pmem_address 0x200), then instruction (0x100) after one IDLE cycle.
REQ-040 d_write=1, addr 0x3000, d_wdata 0x55..55 -> pmem_write=1, pmem_wdata 0x55..55, d_resp on pmem_resp, pmem_read never high.
REQ-041 i_read held, d_read continuously reissued, MAX_D_RUN=4 -> exactly 4 data grants then one instruction grant.
REQ-042 rst pulsed while SERVE_D awaiting pmem_resp -> next cycle IDLE, strobes 0, no d_resp; later pmem_resp ignored.
REQ-043 d_address changed to 0x9999 mid-SERVE_D -> pmem_address stays at latched value until resp.
